// File: rtl/t_toggle_counter_ctrl.sv
// t_toggle_counter_ctrl
//   Sequencer for a WIDTH-bit bank of T flip-flops used as a programmable
//   counter. Each cycle it works out the per-bit toggle enables (t_vec) and
//   applies them to the internal T-flop bank (q <= q ^ t_vec). It supports
//   start/stop, terminal-count detection, and either one-shot or auto-reload
//   operation.
//
// Optional feature macro: TCNT_DOWN_EN
//   When defined, the dir port is present. Down mode loads limit at start,
//   counts down to 0, and reloads to the captured limit.
//   When undefined, the counter counts up only and no down logic is built.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous reset, active-high
//   start        in   1      begin a count run (only looked at in IDLE)
//   stop         in   1      abort the current run
//   limit        in   WIDTH  terminal count, captured at start
//   auto_reload  in   1      1 = restart at terminal, 0 = one-shot
//   dir          in   1      0 = up, 1 = down (TCNT_DOWN_EN only)
//   t_vec        out  WIDTH  combinational toggle enables for this cycle
//   q            out  WIDTH  T-flop bank state (the count)
//   busy         out  1      registered, high whenever not IDLE
//   done         out  1      registered one-cycle pulse per terminal count
module t_toggle_counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
`ifdef TCNT_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] limit_r;
  logic             reload_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] t_vec_s;
  logic [WIDTH-1:0] start_init_s;
  logic [WIDTH-1:0] reload_val_s;
  logic [WIDTH-1:0] step_s;
  logic             terminal_s;
  logic             launch_s;

  // Up-count toggles: bit i flips when every lower bit is 1.
  function automatic logic [WIDTH-1:0] up_toggles(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    logic             all_ones;
    all_ones = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]     = all_ones;
      all_ones = all_ones & v[i];
    end
    return t;
  endfunction

`ifdef TCNT_DOWN_EN
  logic dir_r;

  // Down-count toggles: bit i flips when every lower bit is 0.
  function automatic logic [WIDTH-1:0] down_toggles(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    logic             all_zero;
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i]     = all_zero;
      all_zero = all_zero & ~v[i];
    end
    return t;
  endfunction

  // The load value at start uses the live dir/limit inputs; they are captured
  // on the same edge.
  assign start_init_s = dir   ? limit   : {WIDTH{1'b0}};
  assign reload_val_s = dir_r ? limit_r : {WIDTH{1'b0}};
  assign terminal_s   = dir_r ? (q_r == {WIDTH{1'b0}}) : (q_r == limit_r);
  assign step_s       = dir_r ? down_toggles(q_r) : up_toggles(q_r);

  // Capture the direction for the whole run.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r <= 1'b0;
    end else if (launch_s) begin
      dir_r <= dir;
    end else begin
      dir_r <= dir_r;
    end
  end
`else
  assign start_init_s = {WIDTH{1'b0}};
  assign reload_val_s = {WIDTH{1'b0}};
  assign terminal_s   = (q_r == limit_r);
  assign step_s       = up_toggles(q_r);
`endif

  // A run is launched only from IDLE, and stop overrides start.
  assign launch_s = (state_r == ST_IDLE) && start && !stop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop)                         state_nxt_s = ST_IDLE;
        else if (terminal_s && !reload_r) state_nxt_s = ST_DONE;
        else                              state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Toggle enables. The start load and the reload are both expressed as
  // q ^ target, so the T-flop bank remains the only write path to q.
  always_comb begin
    t_vec_s = {WIDTH{1'b0}};
    if (rst) begin
      t_vec_s = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (launch_s) t_vec_s = q_r ^ start_init_s;
          else          t_vec_s = {WIDTH{1'b0}};
        end
        ST_RUN: begin
          if (stop)              t_vec_s = {WIDTH{1'b0}};
          else if (!terminal_s)  t_vec_s = step_s;
          else if (reload_r)     t_vec_s = q_r ^ reload_val_s;
          else                   t_vec_s = {WIDTH{1'b0}};
        end
        ST_DONE: t_vec_s = {WIDTH{1'b0}};
        default: t_vec_s = {WIDTH{1'b0}};
      endcase
    end
  end

  // T-flop bank, run configuration capture and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r      <= {WIDTH{1'b0}};
      limit_r  <= {WIDTH{1'b0}};
      reload_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      q_r    <= q_r ^ t_vec_s;
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_r == ST_RUN) && !stop && terminal_s;
      if (launch_s) begin
        limit_r  <= limit;
        reload_r <= auto_reload;
      end else begin
        limit_r  <= limit_r;
        reload_r <= reload_r;
      end
    end
  end

  assign t_vec = t_vec_s;
  assign q     = q_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_t_toggle_counter_ctrl.sv
// Testbench for t_toggle_counter_ctrl.
// A behavioural counter model, based on count values and run phases, is
// compared against the DUT on every falling edge. Literal checks at known
// cycles pin the model. Define TCNT_DOWN_EN to build the down-mode tests.
module tb_t_toggle_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] limit = 8'd0;
  logic       auto_reload = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] t_vec;
  logic [7:0] q;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  // Model state: phase 0 = idle, 1 = counting, 2 = finished.
  logic [7:0] m_q = 8'd0;
  int         m_ph = 0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_limit = 8'd0;
  logic       m_reload = 1'b0;
  logic       m_dir = 1'b0;

  t_toggle_counter_ctrl #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .limit(limit),
    .auto_reload(auto_reload),
`ifdef TCNT_DOWN_EN
    .dir(dir),
`endif
    .t_vec(t_vec),
    .q(q),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every cycle: check the registered outputs against the model. Then work
  // out the model's next count from the current inputs; the expected toggle
  // vector is simply the bits that must change.
  always @(negedge clk) begin
    logic [7:0] nq;
    logic [7:0] et;
    int         nph;
    logic       nd;
    logic       term;
    if (armed) begin
      chk("q", q, m_q);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      nq = m_q; nph = m_ph; nd = 1'b0; et = 8'd0;
      if (rst) begin
        nq = 8'd0; nph = 0; m_limit = 8'd0; m_reload = 1'b0; m_dir = 1'b0;
      end else begin
        case (m_ph)
          0: if (start && !stop) begin
            m_limit = limit; m_reload = auto_reload; m_dir = dir;
            nq = dir ? limit : 8'd0;
            nph = 1;
          end
          1: if (stop) begin
            nph = 0;
          end else begin
            term = m_dir ? (m_q == 8'd0) : (m_q == m_limit);
            if (term) begin
              nd = 1'b1;
              if (m_reload) nq = m_dir ? m_limit : 8'd0;
              else          nph = 2;
            end else begin
              nq = m_dir ? m_q - 8'd1 : m_q + 8'd1;
            end
          end
          default: nph = 0;
        endcase
        et = m_q ^ nq;
      end
      chk("t_vec", t_vec, et);
      m_q = nq; m_ph = nph; m_done = nd; m_busy = (nph != 0);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one cycle; returns one cycle after start (cycle N+1).
  task automatic launch(input logic [7:0] lim, input logic ar, input logic d);
    limit = lim; auto_reload = ar; dir = d; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    // Test 1: reset held for two cycles with start high.
    rst = 1'b1; start = 1'b1;
    tick(1);
    armed = 1'b1;
    chk("rst_q", q, 8'd0);
    tick(1);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    tick(2);

    // Test 2: one-shot up count to 5.
    launch(8'd5, 1'b0, 1'b0);
    chk("os_q0", q, 8'd0);
    chk("os_busy0", busy, 1'b1);
    tick(5);
    chk("os_q5", q, 8'd5);
    chk("os_nodone", done, 1'b0);
    tick(1);
    chk("os_done", done, 1'b1);
    chk("os_busy_done", busy, 1'b1);
    tick(1);
    chk("os_busy_fall", busy, 1'b0);
    chk("os_hold", q, 8'd5);
    tick(2);

    // Test 3: auto-reload with limit 3.
    launch(8'd3, 1'b1, 1'b0);
    tick(4);
    chk("ar_wrap_q", q, 8'd0);
    chk("ar_done", done, 1'b1);
    tick(6);
    chk("ar_q2", q, 8'd2);
    chk("ar_busy", busy, 1'b1);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(1);

    // Test 4: stop at 17 with limit 200, then restart.
    launch(8'd200, 1'b0, 1'b0);
    tick(17);
    chk("stop_q17", q, 8'd17);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("stop_freeze", q, 8'd17);
    chk("stop_busy", busy, 1'b0);
    chk("stop_nodone", done, 1'b0);
    tick(1);
    launch(8'd200, 1'b0, 1'b0);
    chk("restart_q", q, 8'd0);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(1);

    // Test 5a: limit 0 gives done two cycles after start.
    launch(8'd0, 1'b0, 1'b0);
    chk("l0_nodone", done, 1'b0);
    tick(1);
    chk("l0_done", done, 1'b1);
    tick(2);
    // Test 5b: start together with stop stays idle.
    start = 1'b1; stop = 1'b1; tick(1);
    chk("ss_idle", busy, 1'b0);
    start = 1'b0; stop = 1'b0; tick(1);
    // Test 5c/d: limit change mid-run is ignored; held start does not restart.
    limit = 8'd4; start = 1'b1; tick(1);
    limit = 8'd1;
    tick(2);
    chk("mid_q2", q, 8'd2);
    tick(2);
    chk("mid_q4", q, 8'd4);
    start = 1'b0;
    tick(1);
    chk("mid_done", done, 1'b1);
    tick(2);

    // Reset in mid-run: the run is aborted with no done pulse.
    launch(8'd50, 1'b0, 1'b0);
    tick(3);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mrst_q", q, 8'd0);
    tick(1);
    chk("mrst_nodone", done, 1'b0);
    tick(1);

`ifdef TCNT_DOWN_EN
    // Test 6: down count from 4, one-shot and reload.
    launch(8'd4, 1'b0, 1'b1);
    chk("dn_q4", q, 8'd4);
    tick(4);
    chk("dn_q0", q, 8'd0);
    tick(1);
    chk("dn_done", done, 1'b1);
    tick(2);
    launch(8'd4, 1'b1, 1'b1);
    tick(5);
    chk("dn_reload", q, 8'd4);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(1);
`endif

    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
